// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 (x^31+x^28+1) checker: self-synchronises, declares lock,
// counts bit errors against a free-running local reference, drops lock on error bursts.
`timescale 1ns/1ps
module prbs31_checker #(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned LOSS_ERRS = 8,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high asynchronous reset
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned SEED_W  = 5;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = 16;

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t               r_state;
  logic [30:0]          r_sreg;
  logic [SEED_W-1:0]    r_seed_cnt;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [WIN_W-1:0]     r_win_err;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic [ERR_W-1:0]     r_err_count;

  logic                 w_pred;
  logic                 w_mis;
  logic [30:0]          w_shift_din;
  logic [WIN_W-1:0]     w_win_err_nxt;

  assign w_pred        = r_sreg[30] ^ r_sreg[27];
  assign w_mis         = din_valid & (din != w_pred);
  assign w_shift_din   = {r_sreg[29:0], din};
  assign w_win_err_nxt = r_win_err + WIN_W'(w_mis);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_SEED;
      r_sreg      <= '1;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (din_valid) begin
        case (r_state)
          ST_VERIFY: begin
            r_sreg <= w_shift_din;
            if (w_mis) begin
              r_state    <= ST_SEED;
              r_seed_cnt <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + MATCH_W'(1);
              if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                r_state   <= ST_LOCKED;
                r_locked  <= 1'b1;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end
            end
          end
          ST_LOCKED: begin
            // Free-run on the prediction so one flipped bit costs exactly one error
            r_sreg <= {r_sreg[29:0], w_pred};
            if (w_mis) begin
              r_err_pulse <= 1'b1;
              if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + ERR_W'(1);
            end
            if (w_win_err_nxt >= WIN_W'(LOSS_ERRS)) begin
              r_state    <= ST_SEED;
              r_locked   <= 1'b0;
              r_seed_cnt <= '0;
            end else if (r_win_cnt == WIN_W'(WINDOW - 1)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_win_err <= w_win_err_nxt;
            end
          end
          default: begin
            // SEED (and the unused encoding): load 31 raw bits, reject the all-zero lockup state
            r_state  <= ST_SEED;
            r_locked <= 1'b0;
            r_sreg   <= w_shift_din;
            if (r_seed_cnt == SEED_W'(30)) begin
              r_seed_cnt <= '0;
              if (w_shift_din != '0) begin
                r_state     <= ST_VERIFY;
                r_match_cnt <= '0;
              end
            end else begin
              r_seed_cnt <= r_seed_cnt + SEED_W'(1);
            end
          end
        endcase
      end
      if (clear) r_err_count <= '0;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: acquisition, error counting, loss/re-lock,
// valid gaps with windowed errors, saturation, clear and asynchronous reset.
`timescale 1ns/1ps
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        clear;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked6, err_pulse6;
  logic [3:0]  err_count6;
  logic [1:0]  state6;

  int total = 0;
  int bad   = 0;
  logic [30:0] g_s;

  always #5 clk = ~clk;

  prbs31_checker u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  prbs31_checker #(.LOCK_CNT(64), .WINDOW(256), .LOSS_ERRS(256), .ERR_W(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked6), .err_pulse(err_pulse6), .err_count(err_count6), .state(state6)
  );

  task automatic do_reset();
    rst_n = 1'b1; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    g_s = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic gen(output logic b);
    b   = g_s[30];
    g_s = {g_s[29:0], g_s[30] ^ g_s[27]};
  endtask

  task automatic step(input logic b, input logic v);
    din = b; din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_gen(input logic flip);
    logic b;
    gen(b);
    step(b ^ flip, 1'b1);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 95; i++) send_gen(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b exp=0", err_pulse); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    total++; if (err_count6 !== 4'd0) begin bad++; $display("FAIL reset_count6 got=%0d exp=0", err_count6); end
  endtask

  task automatic test_acquire();
    int pulses;
    do_reset();
    for (int i = 1; i <= 95; i++) begin
      send_gen(1'b0);
      if (i == 30) begin
        total++; if (state !== 2'b00) begin bad++; $display("FAIL acq_seed30 got=%0d exp=0", state); end
      end
      if (i == 31) begin
        total++; if (state !== 2'b01) begin bad++; $display("FAIL acq_verify31 got=%0d exp=1", state); end
      end
      if (i == 94) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL acq_lock94 got=%0b exp=0", locked); end
      end
      if (i == 95) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL acq_lock95 got=%0b exp=1", locked); end
        total++; if (state !== 2'b10) begin bad++; $display("FAIL acq_state95 got=%0d exp=2", state); end
      end
    end
    pulses = 0;
    for (int i = 96; i <= 10000; i++) begin
      send_gen(1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL acq_pulses got=%0d exp=0", pulses); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL acq_count got=%0d exp=0", err_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL acq_still_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_single_error();
    int pulses;
    do_reset();
    lock_up();
    for (int i = 0; i < 20; i++) send_gen(1'b0);
    send_gen(1'b1);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL single_pulse got=%0b exp=1", err_pulse); end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      send_gen(1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL single_extra_pulses got=%0d exp=0", pulses); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", err_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_locked got=%0b exp=1", locked); end
  endtask

  task automatic test_loss_relock();
    int n;
    do_reset();
    lock_up();
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 9; j++) send_gen(1'b0);
      send_gen(1'b1);
      if (k == 7) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_locked7 got=%0b exp=1", locked); end
      end
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked8 got=%0b exp=0", locked); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL loss_state got=%0d exp=0", state); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL loss_pulse got=%0b exp=1", err_pulse); end
    total++; if (err_count !== 16'd8) begin bad++; $display("FAIL loss_count got=%0d exp=8", err_count); end
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      send_gen(1'b0);
      n++;
    end
    total++; if (n !== 95) begin bad++; $display("FAIL relock_bits got=%0d exp=95", n); end
    total++; if (err_count !== 16'd8) begin bad++; $display("FAIL relock_count got=%0d exp=8", err_count); end
  endtask

  task automatic test_zero_stream();
    int left_seed;
    do_reset();
    left_seed = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1);
      if (state !== 2'b00 || locked !== 1'b0) left_seed++;
    end
    total++; if (left_seed !== 0) begin bad++; $display("FAIL zero_left_seed got=%0d exp=0", left_seed); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_valid_gaps();
    int  n;
    int  lost;
    logic e;
    do_reset();
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      if ($urandom_range(0, 1) == 1) step(1'($urandom_range(0, 1)), 1'b0);
      send_gen(1'b0);
      n++;
    end
    total++; if (n !== 95) begin bad++; $display("FAIL gaps_lock_bits got=%0d exp=95", n); end
    lost = 0;
    for (int w = 0; w < 4; w++) begin
      for (int j = 1; j <= 256; j++) begin
        if ($urandom_range(0, 1) == 1) step(1'($urandom_range(0, 1)), 1'b0);
        e = (j == 1 || j == 40 || j == 80 || j == 120 || j == 160 || j == 200 || j == 256);
        send_gen(e);
        if (locked !== 1'b1) lost++;
        if (e) begin
          total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL gaps_pulse w=%0d j=%0d got=%0b exp=1", w, j, err_pulse); end
          step(1'b0, 1'b0);
          total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL gaps_idle_pulse w=%0d j=%0d got=%0b exp=0", w, j, err_pulse); end
        end
      end
    end
    total++; if (lost !== 0) begin bad++; $display("FAIL gaps_lost got=%0d exp=0", lost); end
    total++; if (err_count !== 16'd28) begin bad++; $display("FAIL gaps_count got=%0d exp=28", err_count); end
  endtask

  task automatic test_saturate_clear_reset();
    int exp_cnt;
    do_reset();
    lock_up();
    total++; if (locked6 !== 1'b1) begin bad++; $display("FAIL sat_locked got=%0b exp=1", locked6); end
    for (int i = 1; i <= 20; i++) begin
      for (int j = 0; j < 4; j++) send_gen(1'b0);
      send_gen(1'b1);
      exp_cnt = (i > 15) ? 15 : i;
      total++; if (err_count6 !== 4'(exp_cnt)) begin bad++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, err_count6, exp_cnt); end
    end
    total++; if (locked6 !== 1'b1) begin bad++; $display("FAIL sat_still_locked got=%0b exp=1", locked6); end
    clear = 1'b1;
    send_gen(1'b1);
    clear = 1'b0;
    total++; if (err_pulse6 !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%0b exp=1", err_pulse6); end
    total++; if (err_count6 !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", err_count6); end
    total++; if (locked6 !== 1'b1) begin bad++; $display("FAIL clr_locked got=%0b exp=1", locked6); end
    send_gen(1'b1);
    total++; if (err_count6 !== 4'd1) begin bad++; $display("FAIL clr_recount got=%0d exp=1", err_count6); end
    rst_n = 1'b1;
    #1;
    total++; if (locked6 !== 1'b0) begin bad++; $display("FAIL arst_locked got=%0b exp=0", locked6); end
    total++; if (err_pulse6 !== 1'b0) begin bad++; $display("FAIL arst_pulse got=%0b exp=0", err_pulse6); end
    total++; if (err_count6 !== 4'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", err_count6); end
    total++; if (state6 !== 2'b00) begin bad++; $display("FAIL arst_state got=%0d exp=0", state6); end
    #1 rst_n = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_relock();
    test_zero_stream();
    test_valid_gaps();
    test_saturate_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
